// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the single-cycle RISC-V core front end.
//   - Opcode constants used by fetch, the control unit and decode.
//   - NOP_INSTR: canonical no-op (addi x0, x0, 0), the reset value of the
//     instruction register.
//   - fetch_state_t: state encoding of the instruction fetch FSM.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // request word from instruction memory
        WAIT = 2'd1,   // request accepted, awaiting the response
        HOLD = 2'd2    // instruction presented to decode
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register for the instruction fetch unit.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (pc <= RESET_PC)
//   advance_i  in   step to the next sequential instruction (pc + 4)
//   redirect_i in   load target_i; has priority over advance_i
//   target_i   in   redirect address; bits [1:0] are forced to 00
//   pc_o       out  current program counter
// -----------------------------------------------------------------------------
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over the sequential step: a taken branch in HOLD drops
    // the held instruction even when decode is consuming it.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ALIGN_MASK;
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;   // wraps silently at 2^XLEN
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch front end: holds the PC, issues one instruction-memory read at a
// time and hands the fetched word to decode. Taken branches redirect the PC
// and any wrong-path fetch is discarded.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised, holds its payload stable until the
// transfer, except that a redirect may change imem_addr or withdraw
// instr_valid. The memory returns exactly one imem_rsp_valid pulse per
// accepted request, with no back-pressure.
//
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   read request toward instruction memory
//   imem_rsp_valid/data         read response from instruction memory
//   instr_valid/ready           instruction handshake toward decode
//   instr, opcode, instr_pc     fetched word, its opcode field, its address
//   branch_taken/target         one-cycle redirect pulse and address
//   dbg_state                   current FSM state (observation only)
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] instr_pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state_q;
    logic            req_valid_q;
    logic            discard_q;
    logic            instr_valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] pc;

    logic req_fire;
    logic pc_advance;

    // req_valid_q only goes high one cycle after reset release, so REQ can
    // be the reset state while the request line stays low during reset.
    assign req_fire   = req_valid_q & imem_req_ready;
    assign pc_advance = (state_q == HOLD) & instr_ready & ~branch_taken;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (pc_advance),
        .redirect_i (branch_taken),
        .target_i   (branch_target),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            req_valid_q   <= 1'b0;
            discard_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                REQ: begin
                    if (req_fire) begin
                        // A redirect in the accept cycle lets the old address
                        // go out; its response must be thrown away.
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                        discard_q   <= branch_taken;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard_q || branch_taken) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                            discard_q   <= 1'b0;
                        end else begin
                            state_q       <= HOLD;
                            instr_valid_q <= 1'b1;
                            instr_q       <= imem_rsp_data;
                            instr_pc_q    <= pc;   // pc still holds the request address
                        end
                    end else if (branch_taken) begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready || branch_taken) begin
                        state_q       <= REQ;
                        req_valid_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= REQ;
                    req_valid_q   <= 1'b1;
                    discard_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[6:0];
    assign instr_pc       = instr_pc_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [6:0]   opcode;
    logic [31:0]  instr_pc;
    logic         branch_taken;
    logic [31:0]  branch_target;
    fetch_state_t dbg_state;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                         input logic i_rdy, input logic br, input logic [31:0] tgt);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_d;
        instr_ready    = i_rdy;
        branch_taken   = br;
        branch_target  = tgt;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_outputs(input string tag, input logic e_rv, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_instr,
                                 input logic [31:0] e_ipc);
        logic [31:0] w;
        w = e_instr;
        check($sformatf("%s req_valid", tag), 32'(imem_req_valid), 32'(e_rv));
        check($sformatf("%s imem_addr", tag), imem_addr, e_addr);
        check($sformatf("%s instr_valid", tag), 32'(instr_valid), 32'(e_iv));
        check($sformatf("%s instr", tag), instr, e_instr);
        check($sformatf("%s opcode", tag), 32'(opcode), 32'(w[6:0]));
        check($sformatf("%s instr_pc", tag), instr_pc, e_ipc);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        i_rdy;
        logic        br;
        logic [31:0] tgt;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t v(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                               input logic i_rdy, input logic br, input logic [31:0] tgt,
                               input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                               input logic [31:0] e_instr, input logic [31:0] e_ipc);
        vec_t r;
        r.rdy = rdy;   r.rsp_v = rsp_v; r.rsp_d = rsp_d; r.i_rdy = i_rdy;
        r.br = br;     r.tgt = tgt;     r.e_rv = e_rv;   r.e_addr = e_addr;
        r.e_iv = e_iv; r.e_instr = e_instr; r.e_ipc = e_ipc;
        return r;
    endfunction

    // random-phase model state
    logic [31:0] model_pc;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          n_consumed;

    initial begin
        // Row k: expected outputs seen during cycle k, inputs driven during cycle k.
        // Cycle 0 is the first cycle with rst_n high.
        //            rdy rsp  rsp_d          ir  br  tgt            rv  addr           iv  instr          ipc
        tbl[0]  = v(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, NOP_INSTR,     32'h0);
        tbl[1]  = v(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, NOP_INSTR,     32'h0);
        tbl[2]  = v(0, 1, 32'h0050_0093, 0, 0, 32'h0,         0, 32'h0,         0, NOP_INSTR,     32'h0);
        tbl[3]  = v(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[4]  = v(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[5]  = v(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[6]  = v(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[7]  = v(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[8]  = v(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h0050_0093, 32'h0);
        tbl[9]  = v(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         0, 32'h0050_0093, 32'h0);
        tbl[10] = v(0, 0, 32'h0,         0, 1, 32'h103,       1, 32'h4,         0, 32'h0050_0093, 32'h0);
        tbl[11] = v(1, 0, 32'h0,         0, 1, 32'h80,        1, 32'h100,       0, 32'h0050_0093, 32'h0);
        tbl[12] = v(0, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h80,        0, 32'h0050_0093, 32'h0);
        tbl[13] = v(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h80,        0, 32'h0050_0093, 32'h0);
        tbl[14] = v(0, 0, 32'h0,         0, 1, 32'h40,        0, 32'h80,        0, 32'h0050_0093, 32'h0);
        tbl[15] = v(0, 1, 32'h2222_2222, 0, 0, 32'h0,         0, 32'h40,        0, 32'h0050_0093, 32'h0);
        tbl[16] = v(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h0050_0093, 32'h0);
        tbl[17] = v(0, 1, 32'h0020_81B3, 0, 0, 32'h0,         0, 32'h40,        0, 32'h0050_0093, 32'h0);
        tbl[18] = v(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h40,        1, 32'h0020_81B3, 32'h40);
        tbl[19] = v(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0020_81B3, 32'h40);
        tbl[20] = v(0, 1, 32'hFE00_0EE3, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0020_81B3, 32'h40);
        tbl[21] = v(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'hFE00_0EE3, 32'hFFFF_FFFC);
        tbl[22] = v(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'hFE00_0EE3, 32'hFFFF_FFFC);

        // ---- reset state ----
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("in_reset", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
        rst_n = 1'b1;

        // ---- table-driven directed sequence ----
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            check_outputs($sformatf("row%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
                          tbl[i].e_instr, tbl[i].e_ipc);
            drive(tbl[i].rdy, tbl[i].rsp_v, tbl[i].rsp_d, tbl[i].i_rdy, tbl[i].br, tbl[i].tgt);
        end

        // ---- asynchronous reset while waiting for a response ----
        @(negedge clk);
        drive_idle();
        check("wait_state", 32'(dbg_state), 32'(WAIT));
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
        check("async_rst state", 32'(dbg_state), 32'(REQ));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'hBAD0_BAD3, 1'b0, 1'b0, 32'h0);   // stale response
        @(negedge clk);
        check_outputs("restart1", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0);
        drive(1'b0, 1'b1, 32'hBAD1_BAD3, 1'b0, 1'b0, 32'h0);   // stale, still in REQ
        @(negedge clk);
        check_outputs("restart2", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("restart3", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
        drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("restart4", 1'b0, 32'h0, 1'b1, 32'h0050_0093, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_outputs("restart5", 1'b1, 32'h4, 1'b0, 32'h0050_0093, 32'h0);
        drive_idle();

        // ---- randomized run against a program-order model ----
        // Decode must see exactly the words at pc, pc+4, ... restarting at
        // the aligned target after every taken branch.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pc   = 32'h0;
        mem_busy   = 1'b0;
        mem_addr   = 32'h0;
        mem_lat    = 0;
        n_consumed = 0;
        begin
            logic        prev_rv, prev_fire, prev_br;
            logic [31:0] prev_addr;
            logic        rdy, rsp_v, i_rdy, br, fire;
            logic [31:0] rsp_d, tgt, w;
            prev_rv = 1'b0; prev_fire = 1'b0; prev_br = 1'b0; prev_addr = 32'h0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                w = instr;
                if (instr_valid)
                    check("rnd opcode", 32'(opcode), 32'(w[6:0]));
                if (imem_req_valid) begin
                    check("rnd one_outstanding", 32'(mem_busy), 32'h0);
                    check("rnd addr_aligned", 32'(imem_addr[1:0]), 32'h0);
                end
                if (prev_rv && !prev_fire && !prev_br && imem_req_valid)
                    check("rnd addr_stable", imem_addr, prev_addr);

                rsp_v = 1'b0;
                rsp_d = $urandom;
                if (mem_busy) begin
                    if (mem_lat == 0) begin
                        rsp_v    = 1'b1;
                        rsp_d    = mem_word(mem_addr);
                        mem_busy = 1'b0;
                    end else begin
                        mem_lat--;
                    end
                end
                rdy  = ($urandom_range(0, 3) != 0);
                fire = imem_req_valid && rdy;
                if (fire) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_addr;
                    mem_lat  = $urandom_range(0, 2);
                end
                i_rdy = ($urandom_range(0, 2) != 0);
                br    = ($urandom_range(0, 15) == 0);
                tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
                drive(rdy, rsp_v, rsp_d, i_rdy, br, tgt);

                if (instr_valid && i_rdy && !br) begin
                    check("rnd instr_pc", instr_pc, model_pc);
                    check("rnd instr", instr, mem_word(model_pc));
                    model_pc = model_pc + 32'd4;
                    n_consumed++;
                end
                if (br) model_pc = tgt & 32'hFFFF_FFFC;

                prev_rv = imem_req_valid; prev_fire = fire; prev_br = br; prev_addr = imem_addr;
            end
        end
        drive_idle();
        check("rnd progress", 32'(n_consumed > 100), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
